// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer
//   Memory-side responder for the AD9254 sample master write bus. Each
//   accepted write lands one 16-bit sample in an on-chip RAM window. The
//   master is paced with master_waitrequest_n. A host read port and
//   fill/error status let software drain the captured samples.
//
//   Ports
//     clk, reset_n            system clock, async active-low reset
//     master_*                sample write bus (chip select and write are
//                             active low / active high respectively)
//     rd_*                    host read port, data valid one cycle later
//     clear                   sync pulse, zeroes fill count and sticky flags
//     wr_count, full          committed in-window writes, saturating
//     overflow, addr_err      sticky error flags
//     rnd_word, rnd_valid     entropy word and strobe
//
//   Optional feature: define ADC_SAMPLE_BUFFER_ENTROPY_EN to collect the
//   LSB of every in-window sample into a 32-bit entropy word. Without the
//   macro, rnd_word and rnd_valid are tied to zero.
//
//   state  | meaning
//   -------+---------------------------------------------------
//   S_IDLE | no write in progress, waitrequest_n low
//   S_WAIT | counting wait states, waitrequest_n low
//   S_ACK  | waitrequest_n high for one cycle, write commits
module adc_sample_buffer #(
    parameter int          ADDR_W      = 10,
    parameter logic [16:0] BASE_ADDR   = 17'h00000,
    parameter int          WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              master_chip_select_n,
    input  logic [16:0]       master_addr,
    input  logic              master_write,
    input  logic [15:0]       master_writedata,
    output logic              master_waitrequest_n,
    input  logic              rd_chip_select_n,
    input  logic              rd_read,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_readdata,
    output logic              rd_readdatavalid,
    input  logic              clear,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              overflow,
    output logic              addr_err,
    output logic [31:0]       rnd_word,
    output logic              rnd_valid
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [16:0] DEPTH   = 17'(2**ADDR_W);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        req, commit, in_win;
    logic [16:0] idx;
    logic [15:0] mem [2**ADDR_W];

    assign req    = !master_chip_select_n && master_write;
    assign commit = (state == S_ACK);
    // Unsigned wrap puts addresses below BASE_ADDR far outside the window.
    assign idx    = master_addr - BASE_ADDR;
    assign in_win = (idx < DEPTH);
    assign full   = wr_count[ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            master_waitrequest_n <= 1'b0;
        end else begin
            state                <= state_next;
            cnt                  <= cnt_next;
            master_waitrequest_n <= (state_next == S_ACK);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_ACK;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_next = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_next = S_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The RAM is not reset; clear only touches the counters and flags.
    always_ff @(posedge clk) begin
        if (commit && in_win) begin
            mem[idx[ADDR_W-1:0]] <= master_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else if (clear) begin
            wr_count <= '0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else if (commit) begin
            if (!in_win) begin
                addr_err <= 1'b1;
            end else if (full) begin
                overflow <= 1'b1;
            end else begin
                wr_count <= wr_count + (ADDR_W+1)'(1);
            end
        end
    end

    // A read and a commit to the same index in one cycle return the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_readdata      <= '0;
            rd_readdatavalid <= 1'b0;
        end else begin
            rd_readdatavalid <= !rd_chip_select_n && rd_read;
            if (!rd_chip_select_n && rd_read) begin
                rd_readdata <= mem[rd_addr];
            end
        end
    end

`ifdef ADC_SAMPLE_BUFFER_ENTROPY_EN
    logic [31:0] ent_sr;
    logic [31:0] ent_shift;
    logic [4:0]  ent_cnt;

    assign ent_shift = {ent_sr[30:0], master_writedata[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_sr    <= '0;
            ent_cnt   <= '0;
            rnd_word  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            rnd_valid <= 1'b0;
            if (commit && in_win) begin
                ent_sr  <= ent_shift;
                ent_cnt <= ent_cnt + 5'd1;
                if (ent_cnt == 5'd31 && !clear) begin
                    rnd_word  <= ent_shift;
                    rnd_valid <= 1'b1;
                end
            end
            if (clear) begin
                ent_cnt <= '0;
            end
        end
    end
`else
    assign rnd_word  = '0;
    assign rnd_valid = 1'b0;
`endif

endmodule
